// File: rtl/arbitro_interfaces.sv
// arbitro_interfaces: ranked two-interface channel arbiter with hold timeout; ARBITRO_PREEMPT_EN enables rank preemption
module arbitro_interfaces #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic [2:0] user0,
  input  logic [2:0] user1,
  input  logic       done,
  output logic       gnt0,
  output logic       gnt1,
  output logic       busy,
  output logic [2:0] active_user,
  output logic [2:0] deferred_user,
  output logic       deferred_valid,
  output logic       timeout,
  output logic       inv_code
);
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic v0, v1, pick1, cur_req, oth_v, hit, preempt;
  logic [2:0] oth_user;
  function automatic logic code_ok(input logic [2:0] c);
    return !(c == 3'b010 || c == 3'b100 || c == 3'b111);
  endfunction
  function automatic logic [2:0] rank(input logic [2:0] c);
    return c == 3'b110 ? 3'd1 : c == 3'b001 ? 3'd2 : c == 3'b011 ? 3'd3 : c == 3'b101 ? 3'd4 : 3'd0;
  endfunction
  // request qualification, winner selection and release conditions
  always_comb begin
    v0 = req0 && code_ok(user0);
    v1 = req1 && code_ok(user1);
    pick1 = v1 && (!v0 || rank(user1) > rank(user0));
    cur_req = state == GRANT1 ? req1 : req0;
    oth_v = state == GRANT1 ? v0 : v1;
    oth_user = state == GRANT1 ? user0 : user1;
    hit = (MAX_HOLD != 0) && cnt == CNT_W'(MAX_HOLD - 1);
`ifdef ARBITRO_PREEMPT_EN
    preempt = oth_v && rank(oth_user) > rank(active_user);
`else
    preempt = 1'b0;
`endif
  end
  // arbitration FSM with registered grant, user report and pulse outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      busy <= 1'b0;
      active_user <= 3'b000;
      deferred_user <= 3'b000;
      deferred_valid <= 1'b0;
      timeout <= 1'b0;
      inv_code <= 1'b0;
    end else begin
      timeout <= 1'b0;
      inv_code <= 1'b0;
      if (state == IDLE) begin
        inv_code <= (req0 && !code_ok(user0)) || (req1 && !code_ok(user1));
        cnt <= '0;
        if (v0 || v1) begin
          state <= pick1 ? GRANT1 : GRANT0;
          gnt0 <= !pick1;
          gnt1 <= pick1;
          busy <= 1'b1;
          active_user <= pick1 ? user1 : user0;
          deferred_valid <= pick1 ? v0 : v1;
          if (pick1 ? v0 : v1) deferred_user <= pick1 ? user0 : user1;
        end
      end else if (done || !cur_req || preempt || hit) begin
        state <= IDLE;
        gnt0 <= 1'b0;
        gnt1 <= 1'b0;
        busy <= 1'b0;
        active_user <= 3'b000;
        deferred_valid <= 1'b0;
        timeout <= !(done || !cur_req || preempt);
      end else begin
        cnt <= cnt + 1'b1;
        deferred_valid <= oth_v;
        if (oth_v) deferred_user <= oth_user;
      end
    end
  end
endmodule

// File: tb/tb_arbitro_interfaces.sv
// tb_arbitro_interfaces: vector table, corner sequences and randomized model check of arbitro_interfaces
module tb_arbitro_interfaces;
  localparam int HOLD = 4;
`ifdef ARBITRO_PREEMPT_EN
  localparam bit PRE = 1'b1;
`else
  localparam bit PRE = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, req0 = 1'b0, req1 = 1'b0, done = 1'b0;
  logic [2:0] user0 = 3'b000, user1 = 3'b000;
  logic gnt0, gnt1, busy, deferred_valid, timeout, inv_code;
  logic [2:0] active_user, deferred_user;
  logic [11:0] outs;
  int total = 0, bad = 0;

  arbitro_interfaces #(.MAX_HOLD(HOLD), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .user0(user0), .user1(user1),
    .done(done), .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .active_user(active_user),
    .deferred_user(deferred_user), .deferred_valid(deferred_valid), .timeout(timeout),
    .inv_code(inv_code)
  );

  always #5 clk = ~clk;
  assign outs = {gnt0, gnt1, busy, active_user, deferred_user, deferred_valid, timeout, inv_code};

  typedef struct {
    logic r0, r1;
    logic [2:0] u0, u1;
    logic d, g0, g1;
    logic [2:0] au, du;
    logic dv, inv, to;
  } vec_t;
  vec_t vec[15];

  int rank_of[8] = '{0, 2, -1, 3, -1, 4, 1, -1};
  int owner = -1, age = 0;
  logic [2:0] m_act = 3'b000, m_def = 3'b000;
  logic m_dv = 1'b0, m_to = 1'b0, m_inv = 1'b0;

  task automatic check(input string name, input logic [11:0] got, input logic [11:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%b want=%b (g0 g1 busy au du dv to inv)", name, got, want);
    end
  endtask

  function automatic logic [11:0] pack(input logic g0, input logic g1, input logic [2:0] au,
                                       input logic [2:0] du, input logic dv, input logic to, input logic inv);
    return {g0, g1, g0 | g1, au, du, dv, to, inv};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_edge();
    logic ok0, ok1, oth_ok, mine, pre;
    logic [2:0] oth;
    ok0 = req0 && rank_of[user0] >= 0;
    ok1 = req1 && rank_of[user1] >= 0;
    m_to = 1'b0;
    m_inv = 1'b0;
    if (owner < 0) begin
      m_inv = (req0 && rank_of[user0] < 0) || (req1 && rank_of[user1] < 0);
      if (ok0 || ok1) begin
        owner = (ok1 && (!ok0 || rank_of[user1] > rank_of[user0])) ? 1 : 0;
        age = 1;
        m_act = owner == 1 ? user1 : user0;
        m_dv = owner == 1 ? ok0 : ok1;
        if (m_dv) m_def = owner == 1 ? user0 : user1;
      end
    end else begin
      oth_ok = owner == 1 ? ok0 : ok1;
      oth = owner == 1 ? user0 : user1;
      mine = owner == 1 ? req1 : req0;
      pre = PRE && oth_ok && rank_of[oth] > rank_of[m_act];
      if (done || !mine || pre) begin
        owner = -1;
      end else if (age == HOLD) begin
        owner = -1;
        m_to = 1'b1;
      end else begin
        age++;
        m_dv = oth_ok;
        if (oth_ok) m_def = oth;
      end
      if (owner < 0) begin
        m_act = 3'b000;
        m_dv = 1'b0;
      end
    end
  endtask

  initial begin
    vec[0]  = '{1, 1, 3'b110, 3'b110, 0, 1, 0, 3'b110, 3'b110, 1, 0, 0};
    vec[1]  = '{1, 1, 3'b110, 3'b110, 1, 0, 0, 3'b000, 3'b110, 0, 0, 0};
    vec[2]  = '{0, 0, 3'b000, 3'b000, 0, 0, 0, 3'b000, 3'b110, 0, 0, 0};
    vec[3]  = '{1, 1, 3'b001, 3'b101, 0, 0, 1, 3'b101, 3'b001, 1, 0, 0};
    vec[4]  = '{1, 0, 3'b001, 3'b101, 1, 0, 0, 3'b000, 3'b001, 0, 0, 0};
    vec[5]  = '{1, 0, 3'b001, 3'b000, 0, 1, 0, 3'b001, 3'b001, 0, 0, 0};
    vec[6]  = '{1, 0, 3'b001, 3'b000, 0, 1, 0, 3'b001, 3'b001, 0, 0, 0};
    vec[7]  = '{0, 0, 3'b001, 3'b000, 0, 0, 0, 3'b000, 3'b001, 0, 0, 0};
    vec[8]  = '{1, 0, 3'b111, 3'b000, 0, 0, 0, 3'b000, 3'b001, 0, 1, 0};
    vec[9]  = '{1, 0, 3'b111, 3'b000, 0, 0, 0, 3'b000, 3'b001, 0, 1, 0};
    vec[10] = '{1, 1, 3'b111, 3'b000, 0, 0, 1, 3'b000, 3'b001, 0, 1, 0};
    vec[11] = '{1, 1, 3'b111, 3'b000, 0, 0, 1, 3'b000, 3'b001, 0, 0, 0};
    vec[12] = '{0, 0, 3'b000, 3'b000, 0, 0, 0, 3'b000, 3'b001, 0, 0, 0};
    vec[13] = '{1, 1, 3'b000, 3'b000, 0, 1, 0, 3'b000, 3'b000, 1, 0, 0};
    vec[14] = '{0, 0, 3'b000, 3'b000, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0};

    step();
    step();
    check("reset_state", outs, 12'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      {req0, req1, user0, user1, done} = {vec[i].r0, vec[i].r1, vec[i].u0, vec[i].u1, vec[i].d};
      step();
      check($sformatf("vec%0d", i), outs,
            pack(vec[i].g0, vec[i].g1, vec[i].au, vec[i].du, vec[i].dv, vec[i].to, vec[i].inv));
    end

    req0 = 1'b1; user0 = 3'b011; req1 = 1'b0; done = 1'b0;
    for (int k = 0; k < HOLD; k++) begin
      step();
      check($sformatf("hold_%0d", k), outs, pack(1, 0, 3'b011, 3'b000, 0, 0, 0));
    end
    step();
    check("timeout_release", outs, pack(0, 0, 3'b000, 3'b000, 0, 1, 0));
    step();
    check("timeout_regrant", outs, pack(1, 0, 3'b011, 3'b000, 0, 0, 0));
    for (int k = 1; k < HOLD; k++) step();
    check("rehold", outs, pack(1, 0, 3'b011, 3'b000, 0, 0, 0));
    done = 1'b1;
    step();
    check("done_at_timeout", outs, pack(0, 0, 3'b000, 3'b000, 0, 0, 0));
    req0 = 1'b0; done = 1'b0;
    step();

    req0 = 1'b1; user0 = 3'b000;
    step();
    check("pre_grant0", outs, pack(1, 0, 3'b000, 3'b000, 0, 0, 0));
    req1 = 1'b1; user1 = 3'b011;
    step();
    if (PRE) begin
      check("preempt_drop", outs, pack(0, 0, 3'b000, 3'b000, 0, 0, 0));
    end else begin
      check("no_preempt_hold", outs, pack(1, 0, 3'b000, 3'b011, 1, 0, 0));
      done = 1'b1;
      step();
      check("no_preempt_done", outs, pack(0, 0, 3'b000, 3'b011, 0, 0, 0));
      done = 1'b0;
    end
    step();
    check("higher_granted", outs, pack(0, 1, 3'b011, 3'b000, 1, 0, 0));
    req0 = 1'b0; req1 = 1'b0;
    step();

    req0 = 1'b1; user0 = 3'b101;
    step();
    check("pre_reset_grant", outs, pack(1, 0, 3'b101, 3'b000, 0, 0, 0));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", outs, 12'd0);
    step();
    step();
    check("reset_held", outs, 12'd0);
    req0 = 1'b0;
    rst_n = 1'b1;

    for (int n = 0; n < 2000; n++) begin
      if (req0) begin
        if ($urandom_range(0, 5) == 0) req0 = 1'b0;
      end else begin
        user0 = 3'($urandom);
        req0 = $urandom_range(0, 1) == 1;
      end
      if (req1) begin
        if ($urandom_range(0, 5) == 0) req1 = 1'b0;
      end else begin
        user1 = 3'($urandom);
        req1 = $urandom_range(0, 1) == 1;
      end
      done = $urandom_range(0, 7) == 0;
      @(posedge clk);
      model_edge();
      #1;
      check($sformatf("rand%0d", n), outs,
            {owner == 0, owner == 1, owner >= 0, m_act, m_def, m_dv, m_to, m_inv});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/arbitro_interfaces.md
Name: arbitro_interfaces

Overview:
- Sequential arbiter that gives one shared output channel to one of two requesting interfaces (0 and 1).
- Each interface presents a 3-bit user code. Code rank decides the winner; ties go to interface 0.
- The grant is held until the owner releases it or a hold timeout expires.
- The code of the losing (deferred) user is reported for the user-notification function.

Parameters:
- MAX_HOLD, 16, maximum grant length in cycles; 0 disables the timeout.
- CNT_W, 5, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req0  input  1  interface 0 requests the channel
- req1  input  1  interface 1 requests the channel
- user0  input  3  user code of interface 0; stable while req0=1
- user1  input  3  user code of interface 1; stable while req1=1
- done  input  1  current owner releases the channel
- gnt0  output  1  channel granted to interface 0
- gnt1  output  1  channel granted to interface 1
- busy  output  1  a grant is active
- active_user  output  3  code of the current owner; 000 when idle
- deferred_user  output  3  code of the waiting, lower-priority user
- deferred_valid  output  1  deferred_user is meaningful
- timeout  output  1  one-cycle pulse on a forced release
- inv_code  output  1  one-cycle pulse when a request carries an invalid code

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low. All outputs are registered.
- Reset values: all outputs 0, FSM in IDLE, counter 0. Asserting rst_n mid-grant drops the grant immediately, with no timeout pulse.
- Rank of valid codes, lowest to highest: 000=0, 110=1, 001=2, 011=3, 101=4.
- Invalid codes: 010, 100, 111. A request with an invalid code is never granted. inv_code pulses in each IDLE cycle where it is seen.
- FSM states: IDLE, GRANT0, GRANT1.
- IDLE: evaluate the valid requests at each edge.
  - Only one valid request: grant that interface.
  - Both valid: grant the higher rank; equal rank grants interface 0.
  - Latency: request sampled at edge N, gntX=1 after edge N.
- Grant entry: on entering GRANTx, latch active_user. If the other interface also has a valid request, latch its code into deferred_user and set deferred_valid=1; otherwise deferred_valid=0.
- While in GRANTx:
  - deferred_valid tracks the other request: it clears the cycle after the other req drops.
  - deferred_user updates if the other interface requests later.
- Release: at an edge where done=1 or reqX=0 in GRANTx, go to IDLE.
  - gnt, busy, active_user and deferred_valid are all cleared.
  - At least one idle cycle separates consecutive grants: release at edge N, earliest new grant at edge N+2.
- Hold counter: reset on grant entry, incremented each GRANT cycle.
  - When MAX_HOLD≠0, counter = MAX_HOLD-1 and done=0: forced release to IDLE, with timeout=1 for exactly one cycle.
  - done and timeout at the same edge: treated as a normal release, no timeout pulse.
- Outputs: gnt0 and gnt1 are never both 1. busy = gnt0|gnt1.
- Fairness: no round-robin. A lower-rank user can starve only while a higher-rank user keeps requesting; the timeout bounds each individual grant.

Optional Feature:
- Macro: ARBITRO_PREEMPT_EN.
- Defined: in GRANTx, if the other interface presents a valid code with strictly higher rank than active_user, the current grant is dropped at that edge (state goes to IDLE, preempt counted as a release, no timeout pulse). The higher-rank interface is granted at the next edge. Equal rank never preempts.
- Undefined: no preemption. A grant ends only by done, req drop, timeout or reset.

Test Plan:
- Reset: rst_n=0 mid-grant -> gnt0=gnt1=busy=0 and active_user=000 immediately. No timeout pulse.
- Tie-break: req0/user0=110 and req1/user1=110 in IDLE -> gnt0=1, active_user=110, deferred_user=110, deferred_valid=1.
- Rank win: user0=001 vs user1=101 -> gnt1=1, deferred_user=001. Then done=1 -> one idle cycle -> gnt0=1 with active_user=001.
- Invalid code: req0 with user0=111, no req1 -> no grant; inv_code pulses each IDLE cycle. Adding req1/user1=000 -> gnt1=1.
- Timeout, MAX_HOLD=4: gnt0 held with done=0 -> gnt0 drops after 4 grant cycles with a 1-cycle timeout pulse. Repeat with done=1 at that edge -> no timeout pulse.
- Preemption, ARBITRO_PREEMPT_EN defined: gnt0 active with user0=000, then req1/user1=011 -> gnt0 drops at the next edge, gnt1=1 one edge later. Without the macro, gnt0 holds until done.
